// File: rtl/wb_stage_if.sv
// rtl/wb_stage_if.sv - execute, memory-response and register-file signals of the writeback stage
// The slave modport is the writeback stage; master is whatever drives execute/memory and observes the outputs.
interface wb_stage_if;
  logic        ex_valid;
  logic        ex_ready;
  logic        ex_wen;
  logic        ex_is_load;
  logic [4:0]  ex_rd;
  logic [31:0] ex_result;
  logic [2:0]  ex_funct3;
  logic [1:0]  ex_addr_lo;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_err;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wd;
  logic        busy_valid;
  logic [4:0]  busy_rd;
  logic        load_err;

  modport slave (
    input  ex_valid, ex_wen, ex_is_load, ex_rd, ex_result, ex_funct3, ex_addr_lo,
    input  mem_rsp_valid, mem_rsp_data, mem_rsp_err,
    output ex_ready, rf_we, rf_rd, rf_wd, busy_valid, busy_rd, load_err
  );

  modport master (
    output ex_valid, ex_wen, ex_is_load, ex_rd, ex_result, ex_funct3, ex_addr_lo,
    output mem_rsp_valid, mem_rsp_data, mem_rsp_err,
    input  ex_ready, rf_we, rf_rd, rf_wd, busy_valid, busy_rd, load_err
  );
endinterface

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - RV32I writeback stage driving the register-file write port, with a one-entry pending-load scoreboard
// Optional WB_TIMEOUT_EN: abandon a load after TIMEOUT_CYCLES WAIT_LOAD cycles without a response.
module wb_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic      clk,
  input  logic      rst,
  wb_stage_if.slave bus
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  logic [0:0]  state_q, state_d;
  logic [4:0]  ld_rd_q, ld_rd_d;
  logic [2:0]  ld_f3_q, ld_f3_d;
  logic [1:0]  ld_lo_q, ld_lo_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_rd_q, rf_rd_d;
  logic [31:0] rf_wd_q, rf_wd_d;
  logic        load_err_q, load_err_d;

  logic        accept;
  logic        ld_bad;
  logic        tmo_hit;

  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] lo,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lo, 3'b000} +: 8];
    h = lo[1] ? w[31:16] : w[15:0];
    case (f3)
      F3_LB:   fmt_load = {{24{b[7]}}, b};
      F3_LH:   fmt_load = {{16{h[15]}}, h};
      F3_LBU:  fmt_load = {24'd0, b};
      F3_LHU:  fmt_load = {16'd0, h};
      default: fmt_load = w;
    endcase
  endfunction

  assign bus.ex_ready   = !rst && (state_q == S_IDLE);
  assign accept         = bus.ex_valid && bus.ex_ready;
  assign bus.rf_we      = rf_we_q;
  assign bus.rf_rd      = rf_rd_q;
  assign bus.rf_wd      = rf_wd_q;
  assign bus.load_err   = load_err_q;
  assign bus.busy_valid = (state_q == S_WAIT);
  assign bus.busy_rd    = ld_rd_q;

  // Illegal load types and misaligned halfword/word accesses never write.
  always_comb begin
    case (ld_f3_q)
      F3_LB, F3_LBU: ld_bad = 1'b0;
      F3_LH, F3_LHU: ld_bad = ld_lo_q[0];
      F3_LW:         ld_bad = (ld_lo_q != 2'b00);
      default:       ld_bad = 1'b1;
    endcase
  end

`ifdef WB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] tmo_cnt_q, tmo_cnt_d;

  assign tmo_hit = (state_q == S_WAIT) && (tmo_cnt_q == TMO_LAST);

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (accept && bus.ex_is_load) begin
      tmo_cnt_d = 16'd0;
    end else if (state_q == S_WAIT) begin
      tmo_cnt_d = tmo_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= 16'd0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  // Without the timeout a load waits forever; the parameter is kept so both builds share one port list.
  assign tmo_hit = 1'b0 & (TIMEOUT_CYCLES == 32'd0);
`endif

  always_comb begin
    state_d    = state_q;
    ld_rd_d    = ld_rd_q;
    ld_f3_d    = ld_f3_q;
    ld_lo_d    = ld_lo_q;
    rf_we_d    = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_wd_d    = rf_wd_q;
    load_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (bus.ex_is_load) begin
            state_d = S_WAIT;
            ld_rd_d = bus.ex_rd;
            ld_f3_d = bus.ex_funct3;
            ld_lo_d = bus.ex_addr_lo;
          end else if (bus.ex_wen && (bus.ex_rd != 5'd0)) begin
            rf_we_d = 1'b1;
            rf_rd_d = bus.ex_rd;
            rf_wd_d = bus.ex_result;
          end
        end
      end
      S_WAIT: begin
        // A response in the same cycle as the timeout takes priority.
        if (bus.mem_rsp_valid) begin
          state_d = S_IDLE;
          if (bus.mem_rsp_err || ld_bad) begin
            load_err_d = 1'b1;
          end else if (ld_rd_q != 5'd0) begin
            rf_we_d = 1'b1;
            rf_rd_d = ld_rd_q;
            rf_wd_d = fmt_load(ld_f3_q, ld_lo_q, bus.mem_rsp_data);
          end
        end else if (tmo_hit) begin
          state_d    = S_IDLE;
          load_err_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ld_rd_q    <= 5'd0;
      ld_f3_q    <= 3'd0;
      ld_lo_q    <= 2'd0;
      rf_we_q    <= 1'b0;
      rf_rd_q    <= 5'd0;
      rf_wd_q    <= 32'd0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ld_rd_q    <= ld_rd_d;
      ld_f3_q    <= ld_f3_d;
      ld_lo_q    <= ld_lo_d;
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_wd_q    <= rf_wd_d;
      load_err_q <= load_err_d;
    end
  end

endmodule
